// File: rtl/binary_encoder_4b2b.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_encoder_4b2b                                          |
// | Description : Priority encoder (highest set bit wins) with a valid/ready   |
// |               handshake on both sides, a 2-entry result FIFO and a        |
// |               saturating counter of accepted multi-hot beats.             |
// | Ports       : clk, reset (sync, active-high)                              |
// |               in_valid/in_ready/in_data[2**N-1:0]   - input beat stream   |
// |               out_valid/out_ready                   - result handshake    |
// |               out_code[N-1:0], out_hit, out_multi   - FIFO head result    |
// |               err_count[ERRW-1:0]                   - multi-hot beat count|
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module binary_encoder_4b2b #(
  parameter int N    = 2,
  parameter int ERRW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_code,
  output logic              out_hit,
  output logic              out_multi,
  output logic [ERRW-1:0]   err_count
);

  localparam int c_IN_W = 2**N;
  // FIFO entry layout: {code, hit, multi}
  localparam int c_EW   = N + 2;

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_EW-1:0] r_head;
  logic [c_EW-1:0] r_tail;
  logic [ERRW-1:0] r_err_count;

  logic [N-1:0]    w_code;
  logic            w_hit;
  logic            w_multi;
  logic [c_EW-1:0] w_enc;
  logic            w_accept;
  logic            w_consume;

  // --------------------------------------------------------------------------
  // Priority encoder: later (higher) indices overwrite earlier ones, so the
  // highest set bit wins. A set bit seen after another set bit flags multi.
  // --------------------------------------------------------------------------
  always_comb begin
    w_code  = '0;
    w_hit   = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < c_IN_W; i++) begin
      if (in_data[i]) begin
        w_multi = w_multi | w_hit;
        w_hit   = 1'b1;
        w_code  = N'(i);
      end
    end
  end

  assign w_enc     = {w_code, w_hit, w_multi};
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Occupancy FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: begin
        if (w_accept) w_state_nxt = c_ONE;
      end
      c_ONE: begin
        if (w_accept && !w_consume)      w_state_nxt = c_TWO;
        else if (!w_accept && w_consume) w_state_nxt = c_EMPTY;
      end
      c_TWO: begin
        if (w_consume) w_state_nxt = c_ONE;
      end
      default: w_state_nxt = c_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM: outputs. in_ready is a pure function of state so it never
  // forms a combinational path from out_ready. Result fields are forced to 0
  // whenever no result is presented.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (r_state == c_EMPTY) || (r_state == c_ONE);
    out_valid = (r_state == c_ONE) || (r_state == c_TWO);
    out_code  = '0;
    out_hit   = 1'b0;
    out_multi = 1'b0;
    if (out_valid) begin
      out_code  = r_head[c_EW-1:2];
      out_hit   = r_head[1];
      out_multi = r_head[0];
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. The head always holds the oldest entry; the tail is only
  // meaningful in TWO. In ONE with simultaneous accept and consume the new
  // beat goes straight into the head, so there is no bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_accept) r_head <= w_enc;
        end
        c_ONE: begin
          if (w_accept && !w_consume) begin
            r_tail <= w_enc;
          end else if (w_accept && w_consume) begin
            r_head <= w_enc;
          end else if (w_consume) begin
            r_head <= '0;
          end
        end
        c_TWO: begin
          if (w_consume) begin
            r_head <= r_tail;
            r_tail <= '0;
          end
        end
        default: begin
          r_head <= '0;
          r_tail <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Error counter: counts multi-hot beats at acceptance, saturating at max.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_accept && w_multi && (r_err_count != {ERRW{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_binary_encoder_4b2b.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_binary_encoder_4b2b                                       |
// | Description : Directed self-checking bench for binary_encoder_4b2b.        |
// |               u_dut uses default parameters; u_sat uses ERRW=2 for the    |
// |               counter saturation scenario.                                |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_binary_encoder_4b2b;

  logic       clk;
  logic       reset;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic       out_hit;
  logic       out_multi;
  logic [7:0] err_count;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [3:0] s_in_data;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [1:0] s_out_code;
  logic       s_out_hit;
  logic       s_out_multi;
  logic [1:0] s_err_count;

  int tests;
  int fails;

  binary_encoder_4b2b #(.N(2), .ERRW(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_hit   (out_hit),
    .out_multi (out_multi),
    .err_count (err_count)
  );

  binary_encoder_4b2b #(.N(2), .ERRW(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_code  (s_out_code),
    .out_hit   (s_out_hit),
    .out_multi (s_out_multi),
    .err_count (s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;      // beat during reset must not be taken
    in_data = 4'b0001;
    out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = 4'b0000;
    s_out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    tests++; if ({out_code, out_hit, out_multi} !== 4'b0000) begin fails++; $display("FAIL reset_outputs got=%b exp=0000", {out_code, out_hit, out_multi}); end
    tests++; if (s_err_count !== 2'd0) begin fails++; $display("FAIL reset_sat_err got=%0d exp=0", s_err_count); end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_code [4];
    exp_code[0] = 4'd0; exp_code[1] = 4'd1; exp_code[2] = 4'd2; exp_code[3] = 4'd3;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = 4'(1 << k);
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sweep_valid[%0d] got=%b exp=1", k, out_valid); end
      tests++; if (out_code !== exp_code[k][1:0]) begin fails++; $display("FAIL sweep_code[%0d] got=%0d exp=%0d", k, out_code, exp_code[k]); end
      tests++; if ({out_hit, out_multi} !== 2'b10) begin fails++; $display("FAIL sweep_hit_multi[%0d] got=%b exp=10", k, {out_hit, out_multi}); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sweep_in_ready[%0d] got=%b exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL sweep_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_zero_multi();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b0000;
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    tests++; if ({out_code, out_hit, out_multi} !== 4'b0000) begin fails++; $display("FAIL zero_result got=%b exp=0000", {out_code, out_hit, out_multi}); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL zero_err got=%0d exp=0", err_count); end
    in_data = 4'b1010;
    step();
    tests++; if ({out_code, out_hit, out_multi} !== 4'b1111) begin fails++; $display("FAIL multi_result got=%b exp=1111", {out_code, out_hit, out_multi}); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL multi_err got=%0d exp=1", err_count); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL multi_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'b0010;
    step();
    tests++; if (out_code !== 2'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_first got=%0d/%b exp=1/1", out_code, out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    in_data = 4'b1000;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_two got=%b exp=0", in_ready); end
    tests++; if (out_code !== 2'd1) begin fails++; $display("FAIL bp_head_two got=%0d exp=1", out_code); end
    in_data = 4'b0100;   // held off while full
    step();
    tests++; if (in_ready !== 1'b0 || out_code !== 2'd1) begin fails++; $display("FAIL bp_hold got=%b/%0d exp=0/1", in_ready, out_code); end
    out_ready = 1'b1;    // consume 1; 0100 still ignored this cycle
    step();
    tests++; if (out_code !== 2'd3 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_second got=%0d/%b exp=3/1", out_code, out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
    step();              // consume 3, accept 0100
    tests++; if (out_code !== 2'd2 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_third got=%0d/%b exp=2/1", out_code, out_valid); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL bp_err got=%0d exp=1", err_count); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'b0010;
    step();
    tests++; if (out_code !== 2'd1) begin fails++; $display("FAIL sim_head got=%0d exp=1", out_code); end
    in_data = 4'b0100;
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL sim_state got=%b%b exp=11", out_valid, in_ready); end
    tests++; if (out_code !== 2'd2) begin fails++; $display("FAIL sim_new_head got=%0d exp=2", out_code); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sim_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_err [5];
    exp_err[0] = 2'd1; exp_err[1] = 2'd2; exp_err[2] = 2'd3; exp_err[3] = 2'd3; exp_err[4] = 2'd3;
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    s_in_data = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++; if (s_err_count !== exp_err[k]) begin fails++; $display("FAIL sat_err[%0d] got=%0d exp=%0d", k, s_err_count, exp_err[k]); end
    end
    tests++; if ({s_out_code, s_out_hit, s_out_multi} !== 4'b1111) begin fails++; $display("FAIL sat_result got=%b exp=1111", {s_out_code, s_out_hit, s_out_multi}); end
    s_in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'b1100;
    step();
    in_data = 4'b0100;
    step();
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL rm_full got=%b%b exp=01", in_ready, out_valid); end
    tests++; if (err_count !== 8'd2) begin fails++; $display("FAIL rm_err_pre got=%0d exp=2", err_count); end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rm_state got=%b%b exp=01", out_valid, in_ready); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rm_err got=%0d exp=0", err_count); end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b0001;
    step();
    tests++; if (out_valid !== 1'b1 || {out_code, out_hit, out_multi} !== 4'b0010) begin fails++; $display("FAIL rm_after got=%b/%b exp=1/0010", out_valid, {out_code, out_hit, out_multi}); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 4'b0000;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = 4'b0000;
    s_out_ready = 1'b0;
    test_reset();
    test_sweep();
    test_zero_multi();
    test_backpressure();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/binary_encoder_4b2b.md
BINARY_ENCODER_4B2B -- requirements
Module: binary_encoder_4b2b

Interface
REQ-001 The module SHALL have parameter N, default 2, giving output code width; the input vector width SHALL be 2**N.
REQ-002 The module SHALL have parameter ERRW, default 8, giving the error counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a beat to encode.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_data  input  2**N  vector to encode (nominally one-hot).
REQ-008 out_valid  output  1  out_code/out_hit/out_multi hold a result.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 out_code  output  N  index of highest set bit of the encoded beat.
REQ-011 out_hit  output  1  encoded beat had at least one bit set.
REQ-012 out_multi  output  1  encoded beat had more than one bit set.
REQ-013 err_count  output  ERRW  saturating count of accepted beats with out_multi condition.

Function
REQ-014 Encoding SHALL be priority, highest index wins: code = max i with in_data[i]=1; in_data=0 SHALL give code 0, hit 0, multi 0.
REQ-015 A beat SHALL be accepted on a cycle where in_valid and in_ready are both 1; a result SHALL be consumed on a cycle where out_valid and out_ready are both 1.
REQ-016 Results SHALL be buffered in a 2-entry FIFO holding {code, hit, multi}, in acceptance order.
REQ-017 Occupancy FSM states SHALL be EMPTY, ONE, TWO; out_valid SHALL be 1 in ONE and TWO; in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-018 Transitions: EMPTY+accept->ONE; ONE+accept+no consume->TWO; ONE+consume+no accept->EMPTY; ONE+accept+consume->ONE; TWO+consume->ONE; all other cases hold state.
REQ-019 Latency SHALL be one cycle: a beat accepted in cycle t into EMPTY SHALL appear with out_valid=1 in cycle t+1.
REQ-020 out_code/out_hit/out_multi SHALL come from the FIFO head register only and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 In ONE with simultaneous accept and consume, the new beat SHALL become the head in the next cycle, with no bubble and no loss.
REQ-022 When in TWO, in_valid SHALL be ignored; no beat SHALL be accepted or overwritten.
REQ-023 in_ready SHALL depend only on state, not combinationally on out_ready.
REQ-024 err_count SHALL increment by 1 in the cycle after an accepted beat with more than one bit set; at 2**ERRW-1 it SHALL hold.
REQ-025 err_count SHALL count at acceptance, independent of when the result is consumed.
REQ-026 When out_valid=0, out_code, out_hit and out_multi SHALL be 0.

Reset
REQ-027 When reset=1 at a clock edge, state SHALL become EMPTY, FIFO contents and err_count SHALL clear to 0, out_valid=0, and in_ready=1 from the next cycle.
REQ-028 A beat presented in the reset cycle SHALL NOT be accepted; a reset mid-operation SHALL discard both buffered entries.

Verification
REQ-029 Sweep: N=2, out_ready=1, in_data=0001,0010,0100,1000 back-to-back -> out_code 0,1,2,3, hit=1, multi=0, each one cycle after accept, err_count=0.
REQ-030 Zero/multi: in_data=0000 -> code 0, hit 0, multi 0; in_data=1010 -> code 3, hit 1, multi 1, err_count 0->1.
REQ-031 Backpressure: out_ready=0, send 0010 then 1000 -> in_ready=0 after two accepts, third beat 0100 held off; release out_ready -> results 1,3,2 in order, none lost.
REQ-032 Simultaneous: in ONE with head code 1, accept 0100 and consume same cycle -> state stays ONE, next head code 2.
REQ-033 Saturation: ERRW=2, five accepted beats of 1111 -> err_count 1,2,3,3,3.
REQ-034 Reset mid-operation: in TWO, assert reset one cycle -> out_valid=0, in_ready=1, err_count=0; following beat 0001 -> code 0 one cycle after accept.
